control_mc: RTL and testbench
=============================

# control_mc

Multi-cycle control unit for the RV32I teaching CPU. It is the successor of the single-cycle combinational decoder. It sequences FETCH/DECODE/EXEC/MEM/WB through an FSM, handshakes with instruction and data memory (req/ack, arbitrary wait states), and adds loads, LUI, JAL and byte-addressed branch offsets. It sits between the instruction memory, register file, ALU, data memory and PC register, and drives all their enables and selects.

## Interface
- XLEN, 32: datapath width; `imm` and `alu_result` width.
- ALU_OP_W, 4: width of `alu_op`.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  `instr` valid this cycle
- instr  in  32  fetched instruction
- alu_result  in  XLEN  ALU output; compare ops return 0/1 in bit 0
- imm  out  XLEN  sign-extended immediate; branch and JAL offsets in bytes
- alu_op  out  ALU_OP_W  ALU operation (codes in package)
- has_imm  out  1  ALU operand B = `imm`
- rf_we  out  1  register write strobe, one cycle
- wb_sel  out  2  writeback source: 0 ALU, 1 dmem, 2 imm (LUI), 3 pc+4 (JAL)
- dmem_req  out  1  data memory request
- dmem_we  out  1  store, qualified by `dmem_req`
- dmem_ack  in  1  data access complete
- pc_we  out  1  PC update strobe, one cycle
- pc_sel  out  1  0: pc+4, 1: pc+imm
- illegal  out  1  sticky: undecodable instruction trapped
- state  out  3  current FSM state (debug)

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: `imem_req`=1 until `imem_ack`. On ack, latch `instr` into the internal IR and go to DECODE.
- DECODE: the registered control word (imm, alu_op, has_imm, wb_sel, class) is loaded from IR. An illegal encoding goes to TRAP.
- EXEC: `alu_op`/`has_imm` are driven. Per instruction class:
  - Branch: compare per funct3. `pc_we`=1; `pc_sel`=1 if taken, else 0. Next state FETCH.
  - ALU, LUI and JAL: next state WB.
  - LW/SW: next state MEM, with `alu_op`=ADD and `has_imm`=1.
- MEM: `dmem_req`=1 and `dmem_we`=(SW), held until `dmem_ack`.
  - SW: on ack, `pc_we`=1 with `pc_sel`=0, then FETCH.
  - LW: on ack, go to WB.
- WB: `rf_we`=1 and `pc_we`=1. `pc_sel`=1 for JAL, else 0. Next state FETCH.
- TRAP: all strobes 0 and `illegal`=1; the FSM stays in TRAP until reset.
- Supported instructions:
  - ADDI/XORI/ORI/ANDI
  - ADD/SUB/XOR/OR/AND
  - LW, SW, LUI, JAL
  - BEQ, BNE
- Any other opcode/funct combination is illegal, including instr=0.
- Immediates: I/S/B/U/J formats decoded to XLEN and sign-extended. The B/J bit 0 is 0, so offsets are byte-valued.
- BEQ/BNE use alu_op=XOR and test `alu_result`==0.

## Timing
- Reset (async assert, sync deassert by the system): state=FETCH, all outputs 0, `illegal`=0, IR=0. `imem_req` rises the first cycle after deassert.
- Strobes (`rf_we`, `pc_we`) last exactly one cycle per instruction. `pc_we` fires exactly once per retired instruction.
- Minimum cycles per instruction with zero-wait memories (ack same cycle as req):
  - Branch: 3
  - ALU/LUI/JAL/SW: 4
  - LW: 5
- Each wait cycle adds one cycle.
- `imem_req`/`dmem_req` stay high and stable, with unchanged `dmem_we`, until ack. An ack while req=0 is ignored.
- Reset during MEM or FETCH drops the request asynchronously. No writeback or PC update follows.
- Outputs are registered or decoded from state plus registered control only. They do not depend combinationally on `instr`.

## Configuration
- CONTROL_MC_BRANCH_EXT_EN:
  - Defined: BLT/BGE use alu_op=SLT, BLTU/BGEU use SLTU. Taken = `alu_result[0]` (BLT/BLTU) or its inverse (BGE/BGEU).
  - Undefined: funct3 100–111 on the branch opcode is illegal → TRAP.

## Structure
- Shared package ctrl_pkg contains:
  - ALU op codes: ADD=0001, SUB=0010, XOR=0100, OR=0110, AND=0111, SLT=1000, SLTU=1001
  - state encodings
  - wb_sel codes
  - opcode constants
- Sub-module ctrl_decode: purely combinational, IR → control word plus illegal flag. control_mc holds the FSM and registers.

## Test plan
- ADDI x1,x0,5 (0x00500093), zero-wait → FETCH, DECODE, EXEC, WB. `imm`=5, `alu_op`=ADD, `has_imm`=1, `rf_we`/`pc_we` pulse in cycle 4, `pc_sel`=0.
- LW x2,4(x0) (0x00402103) with `dmem_ack` delayed 3 cycles → `dmem_req` high 4 cycles with `dmem_we`=0, then WB with `wb_sel`=1; total 8 cycles.
- SW x1,0(x0) (0x00102023) → MEM with `dmem_we`=1. `pc_we` on ack, `rf_we` never asserted.
- BEQ x0,x0,-8 (0xFE000CE3) with `alu_result`=0 → `imm`=0xFFFFFFF8, `pc_we`=1 and `pc_sel`=1 in cycle 3. Same with `alu_result`=1 → `pc_sel`=0.
- instr=0x00000000 → TRAP, `illegal`=1, no strobes for 20 cycles; `rst_n` pulse → FETCH, `illegal`=0.
- BLT (funct3 100), `alu_result`=1: with CONTROL_MC_BRANCH_EXT_EN → `alu_op`=SLT, taken. Without → TRAP. Separately, assert `rst_n`=0 mid-MEM → `dmem_req` falls immediately.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle RV32I control unit.
//   - datapath/field widths
//   - ALU op codes, FSM state encodings, writeback select codes, opcode constants
//   - ctrl_word_t: the registered control word produced by ctrl_decode
//   - branch_taken(): branch resolution from the control word and the ALU result
package ctrl_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned STATE_W  = 3;

  // ALU operation codes
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b1001;

  // FSM states
  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  // Writeback source select
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_DMEM = 2'd1,
    WB_IMM  = 2'd2,
    WB_PC4  = 2'd3
  } wb_sel_e;

  // Instruction class: selects the path through EXEC/MEM/WB
  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_JAL    = 3'd1,
    CLS_BRANCH = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4
  } cls_e;

  // Major opcodes
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Registered control word loaded in DECODE
  typedef struct packed {
    logic [XLEN-1:0]     imm;
    logic [ALU_OP_W-1:0] alu_op;
    logic                has_imm;
    wb_sel_e             wb_sel;
    cls_e                cls;
    logic                br_zero;  // branch condition is alu_result == 0
    logic                br_inv;   // invert branch condition (BNE/BGE/BGEU)
  } ctrl_word_t;

  localparam int unsigned CTRL_W = $bits(ctrl_word_t);

  // Taken when the selected compare holds, optionally inverted
  function automatic logic branch_taken(input ctrl_word_t cw, input logic [XLEN-1:0] res);
    logic cond;
    cond = cw.br_zero ? (res == '0) : res[0];
    return cond ^ cw.br_inv;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational instruction decoder.
//   ir      in   INSTR_W  instruction register contents
//   word    out  CTRL_W   packed ctrl_word_t (imm, alu_op, has_imm, wb_sel, class, branch mode)
//   illegal out  1        encoding not supported
// Build option: CONTROL_MC_BRANCH_EXT_EN adds BLT/BGE/BLTU/BGEU; without it those
// funct3 values on the branch opcode decode as illegal.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output logic [CTRL_W-1:0]  word,
  output logic               illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  ctrl_word_t      cw;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  // Immediate formats; B and J carry an implicit zero LSB so offsets are in bytes
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  always_comb begin
    cw      = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        cw.cls     = CLS_ALU;
        cw.has_imm = 1'b1;
        cw.imm     = imm_i;
        cw.wb_sel  = WB_ALU;
        case (funct3)
          3'b000:  cw.alu_op = ALU_ADD;
          3'b100:  cw.alu_op = ALU_XOR;
          3'b110:  cw.alu_op = ALU_OR;
          3'b111:  cw.alu_op = ALU_AND;
          default: illegal   = 1'b1;
        endcase
      end
      OPC_OP: begin
        cw.cls    = CLS_ALU;
        cw.wb_sel = WB_ALU;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  cw.alu_op = ALU_ADD;
            3'b100:  cw.alu_op = ALU_XOR;
            3'b110:  cw.alu_op = ALU_OR;
            3'b111:  cw.alu_op = ALU_AND;
            default: illegal   = 1'b1;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          cw.alu_op = ALU_SUB;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_LOAD: begin
        cw.cls     = CLS_LOAD;
        cw.alu_op  = ALU_ADD;
        cw.has_imm = 1'b1;
        cw.imm     = imm_i;
        cw.wb_sel  = WB_DMEM;
        illegal    = (funct3 != 3'b010);
      end
      OPC_STORE: begin
        cw.cls     = CLS_STORE;
        cw.alu_op  = ALU_ADD;
        cw.has_imm = 1'b1;
        cw.imm     = imm_s;
        illegal    = (funct3 != 3'b010);
      end
      OPC_LUI: begin
        cw.cls     = CLS_ALU;
        cw.alu_op  = ALU_ADD;
        cw.has_imm = 1'b1;
        cw.imm     = imm_u;
        cw.wb_sel  = WB_IMM;
      end
      OPC_JAL: begin
        cw.cls    = CLS_JAL;
        cw.alu_op = ALU_ADD;
        cw.imm    = imm_j;
        cw.wb_sel = WB_PC4;
      end
      OPC_BRANCH: begin
        cw.cls = CLS_BRANCH;
        cw.imm = imm_b;
        case (funct3)
          3'b000: begin cw.alu_op = ALU_XOR; cw.br_zero = 1'b1; end
          3'b001: begin cw.alu_op = ALU_XOR; cw.br_zero = 1'b1; cw.br_inv = 1'b1; end
`ifdef CONTROL_MC_BRANCH_EXT_EN
          3'b100: cw.alu_op = ALU_SLT;
          3'b101: begin cw.alu_op = ALU_SLT;  cw.br_inv = 1'b1; end
          3'b110: cw.alu_op = ALU_SLTU;
          3'b111: begin cw.alu_op = ALU_SLTU; cw.br_inv = 1'b1; end
`endif
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  assign word = cw;

endmodule

// File: rtl/control_mc.sv
// control_mc: multi-cycle control unit for the RV32I teaching CPU.
// Sequences FETCH/DECODE/EXEC/MEM/WB (plus a sticky TRAP) and drives the enables
// and selects of the instruction memory, register file, ALU, data memory and PC.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req/imem_ack     instruction fetch handshake; instr latched on ack
//   alu_result            ALU output, used for branch resolution
//   imm                   sign-extended immediate (byte offsets for B/J)
//   alu_op, has_imm       ALU operation and operand-B select
//   rf_we, wb_sel         register write strobe and writeback source
//   dmem_req/dmem_we/ack  data memory handshake
//   pc_we, pc_sel         PC update strobe and select (pc+4 / pc+imm)
//   illegal               sticky trap flag
//   state                 current FSM state (debug)
// Build option: CONTROL_MC_BRANCH_EXT_EN (handled in ctrl_decode) enables BLT/BGE/BLTU/BGEU.
// Request/ALU/writeback outputs are registered from the next state; pc_we/pc_sel are
// decoded from the current state and registered control word, qualified by dmem_ack
// (store completion) and alu_result (branch outcome) so the PC updates in that cycle.
module control_mc
  import ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  instr,
  input  logic [XLEN-1:0]     alu_result,
  output logic [XLEN-1:0]     imm,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                has_imm,
  output logic                rf_we,
  output logic [1:0]          wb_sel,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ack,
  output logic                pc_we,
  output logic                pc_sel,
  output logic                illegal,
  output logic [STATE_W-1:0]  state
);

  state_e              state_q;
  state_e              state_d;
  logic [INSTR_W-1:0]  ir_q;
  logic [CTRL_W-1:0]   dec_word;
  logic                dec_illegal;
  ctrl_word_t          ctrl_q;
  ctrl_word_t          ctrl_d;

  logic                imem_req_d;
  logic                dmem_req_d;
  logic                dmem_we_d;
  logic                rf_we_d;
  logic [ALU_OP_W-1:0] alu_op_d;
  logic                has_imm_d;
  logic [1:0]          wb_sel_d;
  logic                illegal_d;

  logic                imem_fire;
  logic                dmem_fire;

  // Acks only count while the matching request is up
  assign imem_fire = imem_req & imem_ack;
  assign dmem_fire = dmem_req & dmem_ack;

  ctrl_decode u_decode (
    .ir      (ir_q),
    .word    (dec_word),
    .illegal (dec_illegal)
  );

  // Next state, next registered outputs, and PC strobes
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    imem_req_d = 1'b0;
    dmem_req_d = 1'b0;
    dmem_we_d  = 1'b0;
    rf_we_d    = 1'b0;
    alu_op_d   = '0;
    has_imm_d  = 1'b0;
    wb_sel_d   = '0;
    illegal_d  = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;

    if (state_q == ST_DECODE) ctrl_d = ctrl_word_t'(dec_word);

    case (state_q)
      ST_FETCH:  if (imem_fire) state_d = ST_DECODE;
      ST_DECODE: state_d = dec_illegal ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        case (ctrl_q.cls)
          CLS_BRANCH: begin
            state_d = ST_FETCH;
            pc_we   = 1'b1;
            pc_sel  = branch_taken(ctrl_q, alu_result);
          end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dmem_fire) begin
          if (ctrl_q.cls == CLS_STORE) begin
            state_d = ST_FETCH;
            pc_we   = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        pc_we   = 1'b1;
        pc_sel  = (ctrl_q.cls == CLS_JAL);
      end
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_FETCH;
    endcase

    // Registered outputs follow the state being entered
    case (state_d)
      ST_FETCH: imem_req_d = 1'b1;
      ST_EXEC: begin
        alu_op_d  = ctrl_d.alu_op;
        has_imm_d = ctrl_d.has_imm;
        wb_sel_d  = ctrl_d.wb_sel;
      end
      ST_MEM: begin
        alu_op_d   = ctrl_d.alu_op;
        has_imm_d  = ctrl_d.has_imm;
        wb_sel_d   = ctrl_d.wb_sel;
        dmem_req_d = 1'b1;
        dmem_we_d  = (ctrl_d.cls == CLS_STORE);
      end
      ST_WB: begin
        alu_op_d  = ctrl_d.alu_op;
        has_imm_d = ctrl_d.has_imm;
        wb_sel_d  = ctrl_d.wb_sel;
        rf_we_d   = 1'b1;
      end
      ST_TRAP:  illegal_d = 1'b1;
      default:  ;
    endcase
  end

  // State, IR, control word and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      ir_q     <= '0;
      ctrl_q   <= '0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      rf_we    <= 1'b0;
      alu_op   <= '0;
      has_imm  <= 1'b0;
      wb_sel   <= '0;
      illegal  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      if (imem_fire) ir_q <= instr;
      imem_req <= imem_req_d;
      dmem_req <= dmem_req_d;
      dmem_we  <= dmem_we_d;
      rf_we    <= rf_we_d;
      alu_op   <= alu_op_d;
      has_imm  <= has_imm_d;
      wb_sel   <= wb_sel_d;
      illegal  <= illegal_d;
    end
  end

  assign imm   = ctrl_q.imm;
  assign state = state_q;

endmodule

// File: tb/tb_control_mc.sv
// tb_control_mc: table-driven directed bench for control_mc, plus hand-written
// sequences for reset, trap hold and reset during a data access.
module tb_control_mc;
  import ctrl_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                imem_req;
  logic                imem_ack;
  logic [31:0]         instr;
  logic [31:0]         alu_result;
  logic [31:0]         imm;
  logic [3:0]          alu_op;
  logic                has_imm;
  logic                rf_we;
  logic [1:0]          wb_sel;
  logic                dmem_req;
  logic                dmem_we;
  logic                dmem_ack;
  logic                pc_we;
  logic                pc_sel;
  logic                illegal;
  logic [2:0]          state;

  always #5 clk = ~clk;

  control_mc dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
    .alu_result(alu_result), .imm(imm), .alu_op(alu_op), .has_imm(has_imm),
    .rf_we(rf_we), .wb_sel(wb_sel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .pc_we(pc_we), .pc_sel(pc_sel), .illegal(illegal), .state(state)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          imem_wait;
    int          dmem_wait;
    logic [31:0] alu_res;
    int          cycles;     // from first imem_req cycle to retire/trap cycle
    int          rf_cycle;   // cycle index of rf_we, 0 = none
    int          dmem_cyc;
    logic        dmem_we;
    logic [3:0]  alu_op;     // seen in EXEC
    logic        has_imm;    // seen in EXEC
    logic [31:0] imm;        // seen in EXEC
    logic [1:0]  wb_sel;     // seen with rf_we
    logic        pc_sel;     // seen with pc_we
    logic        trap;
  } vec_t;

  typedef struct {
    int          cycles;
    int          imem_cyc;
    int          pc_we_cnt;
    int          rf_cnt;
    int          rf_cycle;
    int          dmem_cyc;
    logic        dmem_we;
    logic        we_unstable;
    logic [3:0]  alu_op;
    logic        has_imm;
    logic [31:0] imm;
    logic [1:0]  wb_sel;
    logic        pc_sel;
    logic        trap;
    logic        timeout;
  } obs_t;

  int   n_pass  = 0;
  int   n_total = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] ins, input int iw, input int dw,
                              input logic [31:0] ar, input int cyc, input int rfc, input int dmc,
                              input logic we, input logic [3:0] op, input logic hi,
                              input logic [31:0] im, input logic [1:0] wb, input logic ps,
                              input logic tr);
    vec_t v;
    v.name = name; v.instr = ins; v.imem_wait = iw; v.dmem_wait = dw; v.alu_res = ar;
    v.cycles = cyc; v.rf_cycle = rfc; v.dmem_cyc = dmc; v.dmem_we = we; v.alu_op = op;
    v.has_imm = hi; v.imm = im; v.wb_sel = wb; v.pc_sel = ps; v.trap = tr;
    return v;
  endfunction

  // Runs one instruction from a FETCH cycle with imem_req high; acks after the given waits
  task automatic run_instr(input vec_t v, output obs_t o);
    int   wi;
    int   wd;
    logic done;
    logic we_first;
    logic req_seen;
    o = '{default: 0};
    wi = 0; wd = 0; done = 1'b0; we_first = 1'b0; req_seen = 1'b0;
    instr = v.instr;
    alu_result = v.alu_res;
    for (int c = 0; c < 60 && !done; c++) begin
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      if (state == ST_FETCH && imem_req) begin
        if (wi >= v.imem_wait) imem_ack = 1'b1; else wi++;
      end
      if (state == ST_MEM && dmem_req) begin
        if (wd >= v.dmem_wait) dmem_ack = 1'b1; else wd++;
      end
      @(negedge clk);
      o.cycles++;
      if (imem_req) o.imem_cyc++;
      if (dmem_req) begin
        if (!req_seen) begin we_first = dmem_we; req_seen = 1'b1; end
        else if (dmem_we !== we_first) o.we_unstable = 1'b1;
        o.dmem_cyc++;
        o.dmem_we = o.dmem_we | dmem_we;
      end
      if (state == ST_EXEC) begin o.alu_op = alu_op; o.has_imm = has_imm; o.imm = imm; end
      if (rf_we) begin o.rf_cnt++; o.rf_cycle = o.cycles; o.wb_sel = wb_sel; end
      if (pc_we) begin o.pc_we_cnt++; o.pc_sel = pc_sel; end
      if (state == ST_TRAP) o.trap = illegal;
      done = pc_we || (state == ST_TRAP);
      @(posedge clk); #1;
    end
    if (!done) o.timeout = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic do_reset();
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    obs_t o;
    int   strobes;
    int   ill_cnt;

    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; instr = '0; alu_result = '0;

    // name, instr, iw, dw, alu_res, cycles, rf_cycle, dmem_cyc, dmem_we, alu_op, has_imm, imm, wb_sel, pc_sel, trap
    vecs.push_back(mk("addi",   32'h00500093, 0, 0, 32'd0, 4, 4, 0, 1'b0, ALU_ADD, 1'b1, 32'd5,        2'd0, 1'b0, 1'b0));
    vecs.push_back(mk("lw_w3",  32'h00402103, 0, 3, 32'd0, 8, 8, 4, 1'b0, ALU_ADD, 1'b1, 32'd4,        2'd1, 1'b0, 1'b0));
    vecs.push_back(mk("sw",     32'h00102023, 0, 0, 32'd0, 4, 0, 1, 1'b1, ALU_ADD, 1'b1, 32'd0,        2'd0, 1'b0, 1'b0));
    vecs.push_back(mk("beq_t",  32'hFE000CE3, 0, 0, 32'd0, 3, 0, 0, 1'b0, ALU_XOR, 1'b0, 32'hFFFFFFF8, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("beq_nt", 32'hFE000CE3, 0, 0, 32'd1, 3, 0, 0, 1'b0, ALU_XOR, 1'b0, 32'hFFFFFFF8, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk("bne_t",  32'hFE001CE3, 0, 0, 32'd5, 3, 0, 0, 1'b0, ALU_XOR, 1'b0, 32'hFFFFFFF8, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("add_iw2",32'h002081B3, 2, 0, 32'd0, 6, 6, 0, 1'b0, ALU_ADD, 1'b0, 32'd0,        2'd0, 1'b0, 1'b0));
    vecs.push_back(mk("sub",    32'h402081B3, 0, 0, 32'd0, 4, 4, 0, 1'b0, ALU_SUB, 1'b0, 32'd0,        2'd0, 1'b0, 1'b0));
    vecs.push_back(mk("xori",   32'hFFF04093, 0, 0, 32'd0, 4, 4, 0, 1'b0, ALU_XOR, 1'b1, 32'hFFFFFFFF, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk("ori",    32'h07F06113, 0, 0, 32'd0, 4, 4, 0, 1'b0, ALU_OR,  1'b1, 32'h7F,       2'd0, 1'b0, 1'b0));
    vecs.push_back(mk("lui",    32'h123452B7, 0, 0, 32'd0, 4, 4, 0, 1'b0, ALU_ADD, 1'b1, 32'h12345000, 2'd2, 1'b0, 1'b0));
    vecs.push_back(mk("jal",    32'h010000EF, 0, 0, 32'd0, 4, 4, 0, 1'b0, ALU_ADD, 1'b0, 32'd16,       2'd3, 1'b1, 1'b0));
    vecs.push_back(mk("sw_w",   32'h00102023, 1, 2, 32'd0, 7, 0, 3, 1'b1, ALU_ADD, 1'b1, 32'd0,        2'd0, 1'b0, 1'b0));
    vecs.push_back(mk("mul_ill",32'h022081B3, 0, 0, 32'd0, 3, 0, 0, 1'b0, 4'd0,    1'b0, 32'd0,        2'd0, 1'b0, 1'b1));
`ifdef CONTROL_MC_BRANCH_EXT_EN
    vecs.push_back(mk("blt_t",  32'hFE004CE3, 0, 0, 32'd1, 3, 0, 0, 1'b0, ALU_SLT, 1'b0, 32'hFFFFFFF8, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("bgeu_nt",32'hFE007CE3, 0, 0, 32'd1, 3, 0, 0, 1'b0, ALU_SLTU,1'b0, 32'hFFFFFFF8, 2'd0, 1'b0, 1'b0));
`else
    vecs.push_back(mk("blt_ill",32'hFE004CE3, 0, 0, 32'd1, 3, 0, 0, 1'b0, 4'd0,    1'b0, 32'd0,        2'd0, 1'b0, 1'b1));
    vecs.push_back(mk("bgeu_il",32'hFE007CE3, 0, 0, 32'd1, 3, 0, 0, 1'b0, 4'd0,    1'b0, 32'd0,        2'd0, 1'b0, 1'b1));
`endif

    // Reset values, then an ack during the idle cycle after deassert must be ignored
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.state", 32'(state), 32'(ST_FETCH));
    check("rst.outs", 32'({imem_req, dmem_req, dmem_we, rf_we, pc_we, pc_sel, illegal, has_imm, alu_op, wb_sel}), 32'd0);
    check("rst.imm", imm, 32'd0);
    instr = 32'h00500093;
    imem_ack = 1'b1;
    rst_n = 1'b1;
    #1;
    check("rst.req_low_at_deassert", 32'(imem_req), 32'd0);
    @(posedge clk); #1;
    imem_ack = 1'b0;
    check("rst.ack_ignored_state", 32'(state), 32'(ST_FETCH));
    check("rst.req_rise", 32'(imem_req), 32'd1);

    // Table of single instructions
    foreach (vecs[i]) begin
      run_instr(vecs[i], o);
      check({vecs[i].name, ".timeout"},   32'(o.timeout), 32'd0);
      check({vecs[i].name, ".cycles"},    32'(o.cycles), 32'(vecs[i].cycles));
      check({vecs[i].name, ".imem_cyc"},  32'(o.imem_cyc), 32'(vecs[i].imem_wait + 1));
      check({vecs[i].name, ".pc_we_cnt"}, 32'(o.pc_we_cnt), vecs[i].trap ? 32'd0 : 32'd1);
      check({vecs[i].name, ".rf_cnt"},    32'(o.rf_cnt), (vecs[i].rf_cycle != 0) ? 32'd1 : 32'd0);
      check({vecs[i].name, ".rf_cycle"},  32'(o.rf_cycle), 32'(vecs[i].rf_cycle));
      check({vecs[i].name, ".dmem_cyc"},  32'(o.dmem_cyc), 32'(vecs[i].dmem_cyc));
      check({vecs[i].name, ".dmem_we"},   32'(o.dmem_we), 32'(vecs[i].dmem_we));
      check({vecs[i].name, ".we_stable"}, 32'(o.we_unstable), 32'd0);
      check({vecs[i].name, ".alu_op"},    32'(o.alu_op), 32'(vecs[i].alu_op));
      check({vecs[i].name, ".has_imm"},   32'(o.has_imm), 32'(vecs[i].has_imm));
      check({vecs[i].name, ".imm"},       o.imm, vecs[i].imm);
      check({vecs[i].name, ".wb_sel"},    32'(o.wb_sel), 32'(vecs[i].wb_sel));
      check({vecs[i].name, ".pc_sel"},    32'(o.pc_sel), 32'(vecs[i].pc_sel));
      check({vecs[i].name, ".trap"},      32'(o.trap), 32'(vecs[i].trap));
      if (vecs[i].trap) do_reset();
    end

    // instr = 0 traps; trap holds for 20 cycles with no strobes, then reset clears it
    run_instr(mk("zero", 32'h0, 0, 0, 32'd0, 3, 0, 0, 1'b0, 4'd0, 1'b0, 32'd0, 2'd0, 1'b0, 1'b1), o);
    check("zero.trap", 32'(o.trap), 32'd1);
    check("zero.cycles", 32'(o.cycles), 32'd3);
    strobes = 0;
    ill_cnt = 0;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rf_we || pc_we || imem_req || dmem_req || dmem_we) strobes++;
      if (illegal && state == ST_TRAP) ill_cnt++;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    check("trap.no_strobes", 32'(strobes), 32'd0);
    check("trap.sticky", 32'(ill_cnt), 32'd20);
    do_reset();
    check("trap.reset_state", 32'(state), 32'(ST_FETCH));
    check("trap.reset_illegal", 32'(illegal), 32'd0);

    // Reset asserted while a load waits in MEM drops dmem_req without a clock edge
    instr = 32'h00402103;
    imem_ack = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midmem.state", 32'(state), 32'(ST_MEM));
    check("midmem.req_before", 32'(dmem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midmem.req_drop", 32'(dmem_req), 32'd0);
    check("midmem.state_fetch", 32'(state), 32'(ST_FETCH));
    @(negedge clk);
    rst_n = 1'b1;
    strobes = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rf_we || pc_we || dmem_req) strobes++;
    end
    check("midmem.no_wb_or_pc", 32'(strobes), 32'd0);
    check("midmem.refetch_req", 32'(imem_req), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
